// File: rtl/cmac_link_pkg.sv
// Shared definitions for the CMAC link manager: state encoding, drop counter
// width and the Moore decode from state to control outputs.
package cmac_link_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ALIGN = 2'd1;
  localparam logic [1:0] ST_LINK_UP    = 2'd2;
  localparam logic [1:0] ST_RESET_REQ  = 2'd3;

  localparam int DROP_W = 16;

  typedef struct packed {
    logic rx_enable;
    logic tx_enable;
    logic send_rfi;
    logic link_up;
    logic reset_req;
  } ctl_t;

  function automatic ctl_t decode_ctl(input logic [1:0] st);
    ctl_t c;
    c = '0;
    case (st)
      ST_WAIT_ALIGN: begin
        c.rx_enable = 1'b1;
        c.send_rfi  = 1'b1;
      end
      ST_LINK_UP: begin
        c.rx_enable = 1'b1;
        c.tx_enable = 1'b1;
        c.link_up   = 1'b1;
      end
      ST_RESET_REQ: c.reset_req = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/xpm_cdc_single.sv
// Behavioural stand-in for the vendor single-bit synchronizer, covering the
// parameters this design uses (DEST_SYNC_FF >= 2, optional source register).
module xpm_cdc_single #(
  parameter int DEST_SYNC_FF  = 4,
  parameter int SRC_INPUT_REG = 1
) (
  input  logic src_clk,
  input  logic src_in,
  input  logic dest_clk,
  output logic dest_out
);

  logic                    src_q;
  logic                    sync_in;
  logic [DEST_SYNC_FF-1:0] sync_q;

  always_ff @(posedge src_clk) src_q <= src_in;

  assign sync_in = (SRC_INPUT_REG != 0) ? src_q : src_in;

  // NOTE: synchronizer flops are deliberately reset-free; a reset here would
  // just add another asynchronous path into the metastability chain.
  always_ff @(posedge dest_clk) sync_q <= {sync_q[DEST_SYNC_FF-2:0], sync_in};

  assign dest_out = sync_q[DEST_SYNC_FF-1];

endmodule

// File: rtl/cmac_link_mgr.sv
// Brings up and supervises a 100G CMAC link: debounces RX alignment, gates the
// CMAC enables, requests re-resets on alignment timeout and counts link drops.
module cmac_link_mgr
  import cmac_link_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES     = 100000000,
  parameter int unsigned RESET_PULSE_CYCLES = 64
) (
  input  logic              stream_clk,
  input  logic              stream_resetn,
  input  logic              link_enable,
  input  logic              stat_rx_aligned,
  output logic              ctl_rx_enable,
  output logic              ctl_tx_enable,
  output logic              ctl_tx_send_rfi,
  output logic              link_up,
  output logic              reset_req,
  output logic [DROP_W-1:0] drop_count
);

  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1)    ? $clog2(DEBOUNCE_CYCLES)    : 1;
  localparam int PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [31:0]        TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic               aligned_s;
  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [31:0]        timer;
  logic [DEB_W-1:0]   deb_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  ctl_t               ctl_q;
  logic               stay_wait;
  logic               stay_reset;

  xpm_cdc_single #(
    .DEST_SYNC_FF (2),
    .SRC_INPUT_REG(0)
  ) u_aligned_sync (
    .src_clk (stream_clk),
    .src_in  (stat_rx_aligned),
    .dest_clk(stream_clk),
    .dest_out(aligned_s)
  );

  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    if (!link_enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       next_state = ST_WAIT_ALIGN;
        ST_WAIT_ALIGN: begin
          // Debounce completion beats a coincident timeout.
          if (aligned_s && (deb_cnt == DEB_LAST)) next_state = ST_LINK_UP;
          else if (timer == TIMER_LAST)           next_state = ST_RESET_REQ;
        end
        ST_LINK_UP:    if (!aligned_s) next_state = ST_WAIT_ALIGN;
        ST_RESET_REQ:  if (pulse_cnt == PULSE_LAST) next_state = ST_WAIT_ALIGN;
        default:       next_state = ST_IDLE;
      endcase
    end
  end

  // Counters run only while staying in their state, so they read zero on entry.
  assign stay_wait  = (state == ST_WAIT_ALIGN) && (next_state == ST_WAIT_ALIGN);
  assign stay_reset = (state == ST_RESET_REQ)  && (next_state == ST_RESET_REQ);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge stream_clk or negedge stream_resetn) begin
    if (!stream_resetn) begin
      state      <= ST_IDLE;
      timer      <= '0;
      deb_cnt    <= '0;
      pulse_cnt  <= '0;
      drop_count <= '0;
      ctl_q      <= '0;
    end else begin
      state     <= next_state;
      timer     <= stay_wait ? timer + 32'd1 : '0;
      deb_cnt   <= (stay_wait && aligned_s) ? deb_cnt + DEB_W'(1) : '0;
      pulse_cnt <= stay_reset ? pulse_cnt + PULSE_W'(1) : '0;
      if ((state == ST_LINK_UP) && (next_state == ST_WAIT_ALIGN) && (drop_count != '1))
        drop_count <= drop_count + DROP_W'(1);
      ctl_q <= decode_ctl(next_state);
    end
  end

  assign ctl_rx_enable   = ctl_q.rx_enable;
  assign ctl_tx_enable   = ctl_q.tx_enable;
  assign ctl_tx_send_rfi = ctl_q.send_rfi;
  assign link_up         = ctl_q.link_up;
  assign reset_req       = ctl_q.reset_req;

endmodule
